// File: rtl/serial_mag_comparator_ctrl.sv
// serial_mag_comparator_ctrl: MSB-first bit-serial magnitude compare through an external 1-bit comparator
module serial_mag_comparator_ctrl #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             a_bit,
   output logic             b_bit,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b,
   output logic             cmp_err,
   output logic [CW-1:0]    bits_used
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [CW-1:0] cnt;
   logic one_hot;
   assign one_hot = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
   assign a_bit = (state == SHIFT) & a_sr[WIDTH-1];
   assign b_bit = (state == SHIFT) & b_sr[WIDTH-1];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr <= '0;
         b_sr <= '0;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         {a_gt_b, a_eq_b, a_lt_b, cmp_err} <= 4'b0000;
         bits_used <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sr <= a_in;
               b_sr <= b_in;
               cnt <= CW'(WIDTH - 1);
               {a_gt_b, a_eq_b, a_lt_b, cmp_err} <= 4'b0000;
               bits_used <= '0;
               busy <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               bits_used <= bits_used + 1'b1;
               // any non-one-hot code aborts with only the error flag set
               if (!one_hot || cmp_gt || cmp_lt || cnt == '0) begin
                  {a_gt_b, a_eq_b, a_lt_b, cmp_err} <= one_hot ? {cmp_gt, cmp_eq, cmp_lt, 1'b0} : 4'b0001;
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= DONE;
               end else begin
                  a_sr <= a_sr << 1;
                  b_sr <= b_sr << 1;
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// tb_serial_mag_comparator_ctrl: random and directed checks against a per-transaction reference model
module tb_serial_mag_comparator_ctrl;
   localparam int W = 8;
   localparam int CW = $clog2(W + 1);
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
   logic [W-1:0] a_in = '0, b_in = '0;
   logic a_bit, b_bit, cmp_gt, cmp_eq, cmp_lt, busy, done, a_gt_b, a_eq_b, a_lt_b, cmp_err;
   logic [CW-1:0] bits_used;
   int checks = 0, failures = 0;
   int inj_pos = 0;
   logic [2:0] inj_code = '0;
   int m_p = 0, m_bad = 0, m_used = 0;
   logic [2:0] m_code = '0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic [11:0] m_ref = '0;
   logic [3:0] m_res = '0;
   logic [7:0] mk;
   logic m_sh, m_dn, inj;
   logic [8+CW-1:0] act_vec, exp_vec;
   logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

   serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .a_bit(a_bit), .b_bit(b_bit), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
      .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
      .cmp_err(cmp_err), .bits_used(bits_used)
   );

   always #5 clk = ~clk;

   // result of a whole compare: {bits examined, gt, eq, lt, err}
   function automatic logic [11:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int bad);
      for (int n = 1; n <= W; n++) begin
         if (n == bad) return {8'(n), 4'b0001};
         if (a[W-n] != b[W-n]) return {8'(n), a[W-n] ? 4'b1000 : 4'b0010};
      end
      return {8'(W), 4'b0100};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   assign mk = m_ref[11:4];
   assign m_sh = m_p != 0 && m_p <= int'(mk);
   assign m_dn = m_p != 0 && m_p == int'(mk) + 1;
   assign inj = m_bad != 0 && m_p == m_bad && m_sh;
   assign {cmp_gt, cmp_eq, cmp_lt} = inj ? m_code : {a_bit & ~b_bit, a_bit ~^ b_bit, ~a_bit & b_bit};
   assign act_vec = {busy, done, a_bit, b_bit, a_gt_b, a_eq_b, a_lt_b, cmp_err, bits_used};
   assign exp_vec = {m_sh, m_dn, m_sh ? m_a[W-m_p] : 1'b0, m_sh ? m_b[W-m_p] : 1'b0, m_res,
                     CW'(m_sh ? m_p - 1 : m_used)};

   // m_p: 0 idle, else edges since the accepted start (k+1 means the done cycle)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p <= 0;
         m_res <= '0;
         m_used <= 0;
         m_bad <= 0;
         m_ref <= '0;
      end else if (m_p == 0) begin
         if (start) begin
            m_p <= 1;
            m_a <= a_in;
            m_b <= b_in;
            m_bad <= inj_pos;
            m_code <= inj_code;
            m_ref <= ref_cmp(a_in, b_in, inj_pos);
            m_res <= '0;
            m_used <= 0;
         end
      end else if (m_p == int'(mk)) begin
         m_p <= m_p + 1;
         m_res <= m_ref[3:0];
         m_used <= int'(mk);
      end else if (m_p > int'(mk)) m_p <= 0;
      else m_p <= m_p + 1;
   end

   always @(negedge clk) chk("cycle", 64'(act_vec), 64'(exp_vec));

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int pos, input logic [2:0] code,
                     input bit rp, output int lat, output logic [1:0] first);
      @(negedge clk);
      a_in = a;
      b_in = b;
      inj_pos = pos;
      inj_code = code;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      first = {a_bit, b_bit};
      lat = 0;
      for (int i = 0; i < 3 * W; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) break;
         if (rp && lat == 2) begin
            start = 1'b1;
            a_in = W'($urandom);
            b_in = W'($urandom);
         end else start = 1'b0;
      end
      chk("done_seen", 64'(done), 64'd1);
      start = rp;
      if (rp) a_in = ~a_in;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int lat;
      logic [1:0] first;
      logic [W-1:0] a, b;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", 64'(act_vec), 64'd0);
      rst_n = 1'b1;
      op(8'h80, 8'h00, 0, 3'b000, 1'b0, lat, first);
      chk("gt_first_bits", 64'(first), 64'b10);
      chk("gt_latency", 64'(lat), 64'd1);
      chk("gt_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b1000);
      chk("gt_bits_used", 64'(bits_used), 64'd1);
      op(8'h5A, 8'h5B, 0, 3'b000, 1'b0, lat, first);
      chk("lt_latency", 64'(lat), 64'd8);
      chk("lt_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b0010);
      chk("lt_bits_used", 64'(bits_used), 64'd8);
      op(8'hC3, 8'hC3, 0, 3'b000, 1'b0, lat, first);
      chk("eq_latency", 64'(lat), 64'd8);
      chk("eq_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b0100);
      chk("eq_bits_used", 64'(bits_used), 64'd8);
      op(8'hA5, 8'hA5, 3, 3'b110, 1'b0, lat, first);
      chk("err_latency", 64'(lat), 64'd3);
      chk("err_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b0001);
      chk("err_bits_used", 64'(bits_used), 64'd3);
      op(8'h3C, 8'h3D, 0, 3'b000, 1'b1, lat, first);
      chk("restart_latency", 64'(lat), 64'd8);
      chk("restart_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b0010);
      @(negedge clk);
      a_in = 8'h01;
      b_in = 8'h02;
      inj_pos = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 64'(act_vec), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      op(8'h01, 8'h02, 0, 3'b000, 1'b0, lat, first);
      chk("post_reset_latency", 64'(lat), 64'd7);
      chk("post_reset_result", 64'({a_gt_b, a_eq_b, a_lt_b, cmp_err}), 64'b0010);
      chk("post_reset_bits_used", 64'(bits_used), 64'd7);
      for (int i = 0; i < 80; i++) begin
         a = W'($urandom);
         case ($urandom_range(0, 2))
            0: b = a;
            1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
            default: b = W'($urandom);
         endcase
         op(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0,
            bad_codes[$urandom_range(0, 4)], $urandom_range(0, 4) == 0, lat, first);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end
endmodule
